// File: rtl/wisc_mem_arb_pkg.sv
// Shared types and defaults for the WISC memory arbiter.
// Optional feature macro used by the arbiter: WISC_ARB_FAIR_EN (F anti-starvation).
package wisc_mem_arb_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } arb_state_e;

  // Which requester owns the in-flight transaction
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_M = 1'b1;

  // Operation kind held alongside the address
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Default widths and fairness threshold
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/wisc_mem_arb_latch.sv
// Holds the granted request (address, write data, op, owner) for the
// duration of a mem_system transaction. Loaded only in the IDLE issue cycle.
module wisc_mem_arb_latch
  import wisc_mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              op_i,
  input  logic              owner_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              op_o,
  output logic              owner_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_q, op_d;
  logic              owner_q, owner_d;

  // Capture the winner's request when enabled, otherwise hold
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    owner_d = owner_q;
    if (en) begin
      addr_d  = addr_i;
      wdata_d = wdata_i;
      op_d    = op_i;
      owner_d = owner_i;
    end
  end

  // Request registers; cleared by reset so mem_addr/mem_wdata idle at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_RD;
      owner_q <= OWN_F;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      owner_q <= owner_d;
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign op_o    = op_q;
  assign owner_o = owner_q;

endmodule

// File: rtl/wisc_mem_arbiter.sv
// Arbiter between the fetch port (F, read-only) and the memory-stage port
// (M, read/write) in front of the single shared mem_system. Turns level-held
// requests into one-cycle Rd/Wr issue pulses, holds Addr/DataIn until Done and
// steers DataOut plus a done pulse back to the owning requester.
// Optional feature: define WISC_ARB_FAIR_EN to let F win after STARVE_MAX
// consecutive M grants while F waits; without it M has strict priority.
module wisc_mem_arbiter
  import wisc_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              f_rd,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_data,
  output logic              f_done,
  output logic              f_stall,
  // memory-stage port
  input  logic              m_rd,
  input  logic              m_wr,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_done,
  output logic              m_stall,
  // mem_system side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_err,
  output logic              err
);

  // A threshold of zero would hand every contested slot to F
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("wisc_mem_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_e        state_q, state_d;
  logic              err_q, err_d;

  logic              m_req;
  logic              in_idle;
  logic              illegal;
  logic              f_force;
  logic              win_valid;
  logic              win_owner;
  logic              win_op;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              issue_en;
  logic              done_any;
  logic              done_owner;

  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_op;
  logic              lat_owner;

  assign m_req = m_rd | m_wr;

  // Nothing is issued or acknowledged while reset is held, so outputs
  // clear the moment rst rises rather than at the next edge.
  assign in_idle = (state_q == IDLE) && !rst;

  // Simultaneous read and write from M is a protocol violation
  assign illegal = in_idle && m_rd && m_wr;

`ifdef WISC_ARB_FAIR_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign f_force = (starve_q == CNT_W'(STARVE_MAX));

  // Count M grants taken while F is waiting; any F grant or idle F resets it
  always_comb begin
    starve_d = starve_q;
    if (!f_rd) begin
      starve_d = '0;
    end else if (issue_en && (win_owner == OWN_F)) begin
      starve_d = '0;
    end else if (issue_en && (win_owner == OWN_M) && !f_force) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign f_force = 1'b0;
`endif

  // Pick the requester to issue: M holds the older instruction so it wins,
  // unless F has been passed over too often and the fairness override fires.
  always_comb begin
    win_valid = 1'b0;
    win_owner = OWN_F;
    if (m_req && !(f_force && f_rd)) begin
      win_valid = 1'b1;
      win_owner = OWN_M;
    end else if (f_rd) begin
      win_valid = 1'b1;
      win_owner = OWN_F;
    end
  end

  // F only ever reads and never carries write data
  assign win_op    = (win_owner == OWN_M) ? (m_wr ? OP_WR : OP_RD) : OP_RD;
  assign win_addr  = (win_owner == OWN_M) ? m_addr : f_addr;
  assign win_wdata = (win_owner == OWN_M) ? m_wdata : '0;

  assign issue_en = in_idle && win_valid && !illegal;

  wisc_mem_arb_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_latch (
    .clk     (clk),
    .rst     (rst),
    .en      (issue_en),
    .addr_i  (win_addr),
    .wdata_i (win_wdata),
    .op_i    (win_op),
    .owner_i (win_owner),
    .addr_o  (lat_addr),
    .wdata_o (lat_wdata),
    .op_o    (lat_op),
    .owner_o (lat_owner)
  );

  // Issue pulse is combinational in the IDLE cycle; afterwards the cache
  // sees the latched request. DataIn is only meaningful for writes.
  assign mem_rd    = issue_en && (win_op == OP_RD);
  assign mem_wr    = issue_en && (win_op == OP_WR);
  assign mem_addr  = issue_en ? win_addr : lat_addr;
  assign mem_wdata = issue_en ? ((win_op == OP_WR) ? win_wdata : '0)
                              : ((lat_op == OP_WR) ? lat_wdata : '0);

  // Done is accepted in the issue cycle or in WAIT; an erroring cycle never
  // acknowledges. In the issue cycle the owner is the current winner.
  assign done_any   = mem_done && !mem_err && !rst &&
                      (issue_en || (state_q == WAIT));
  assign done_owner = issue_en ? win_owner : lat_owner;

  assign f_done  = done_any && (done_owner == OWN_F);
  assign m_done  = done_any && (done_owner == OWN_M);
  assign f_data  = f_done ? mem_rdata : '0;
  assign m_data  = m_done ? mem_rdata : '0;

  assign f_stall = f_rd & ~f_done;
  assign m_stall = (m_rd | m_wr) & ~m_done;

  assign err = err_q;

  // Next-state: errors dominate and are sticky until reset; a done in the
  // issue cycle keeps the arbiter in IDLE.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (mem_err || illegal) begin
      state_d = ERROR;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE:    if (issue_en && !mem_done) state_d = WAIT;
        WAIT:    if (mem_done) state_d = IDLE;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  // Arbiter state and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wisc_mem_arbiter.sv
// Bench for wisc_mem_arbiter: directed scenarios followed by a randomized
// phase scored against a transaction-level model of the arbiter and memory.
module tb_wisc_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SM = 4;

`ifdef WISC_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          f_rd;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_data;
  logic          f_done, f_stall;
  logic          m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_data;
  logic          m_done, m_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rd, mem_wr, mem_done, mem_err, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wisc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .f_rd(f_rd), .f_addr(f_addr), .f_data(f_data), .f_done(f_done), .f_stall(f_stall),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_data(m_data), .m_done(m_done), .m_stall(m_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic clr_in();
    f_rd = 0; f_addr = '0; m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    mem_done = 0; mem_err = 0; mem_rdata = '0;
  endtask

  // random-phase model state
  logic [DW-1:0] mem_model [64];
  bit            fp, mp, mwr, busy, own_m, issuing, exp_fd, exp_md;
  logic [AW-1:0] fa, ma, cur_addr;
  logic [DW-1:0] mwd, rd_val;
  int            rem, starve;
  bit            exp_f;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clr_in();

    // reset state
    probe();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_f_done", f_done, 0);
    chk("rst_m_done", m_done, 0);
    step(); f_rd = 1; m_wr = 1;
    probe();
    chk("rst_no_issue_rd", mem_rd, 0);
    chk("rst_no_issue_wr", mem_wr, 0);
    chk("rst_f_stall", f_stall, 1);
    chk("rst_m_stall", m_stall, 1);
    step(); clr_in(); rst = 0;
    probe();
    chk("idle_mem_rd", mem_rd, 0);

    // single F read, done three cycles after issue
    step(); f_rd = 1; f_addr = 16'h0040;
    probe();
    chk("t1_issue_rd", mem_rd, 1);
    chk("t1_issue_wr", mem_wr, 0);
    chk("t1_issue_addr", mem_addr, 16'h0040);
    chk("t1_stall", f_stall, 1);
    for (int i = 0; i < 2; i++) begin
      step(); probe();
      chk("t1_wait_rd", mem_rd, 0);
      chk("t1_wait_addr", mem_addr, 16'h0040);
      chk("t1_wait_done", f_done, 0);
    end
    step(); mem_done = 1; mem_rdata = 16'hBEEF;
    probe();
    chk("t1_f_done", f_done, 1);
    chk("t1_f_data", f_data, 16'hBEEF);
    chk("t1_m_done", m_done, 0);
    chk("t1_m_data", m_data, 0);
    chk("t1_f_stall", f_stall, 0);
    step(); clr_in();
    probe();
    chk("t1_after_done", f_done, 0);
    chk("t1_after_rd", mem_rd, 0);
    chk("t1_after_data", f_data, 0);

    // F and M write arrive together: M first, then F
    step(); f_rd = 1; f_addr = 16'h0200; m_wr = 1; m_addr = 16'h0100; m_wdata = 16'h1234;
    probe();
    chk("t2_m_wr", mem_wr, 1);
    chk("t2_m_rd", mem_rd, 0);
    chk("t2_m_addr", mem_addr, 16'h0100);
    chk("t2_m_wdata", mem_wdata, 16'h1234);
    step(); mem_done = 1; mem_rdata = 16'h7777;
    probe();
    chk("t2_m_done", m_done, 1);
    chk("t2_m_data", m_data, 16'h7777);
    chk("t2_f_notdone", f_done, 0);
    chk("t2_f_stall", f_stall, 1);
    step(); m_wr = 0; mem_done = 0; mem_rdata = '0;
    probe();
    chk("t2_f_rd", mem_rd, 1);
    chk("t2_f_addr", mem_addr, 16'h0200);
    chk("t2_f_wdata", mem_wdata, 0);
    step(); mem_done = 1; mem_rdata = 16'h5555;
    probe();
    chk("t2_f_done", f_done, 1);
    chk("t2_f_data", f_data, 16'h5555);
    step(); clr_in(); probe();

    // done in the issue cycle stays IDLE
    step(); m_rd = 1; m_addr = 16'h0300; mem_done = 1; mem_rdata = 16'hA5A5;
    probe();
    chk("t3_rd", mem_rd, 1);
    chk("t3_m_done", m_done, 1);
    chk("t3_m_data", m_data, 16'hA5A5);
    chk("t3_m_stall", m_stall, 0);
    step(); m_rd = 0; mem_done = 0; f_rd = 1; f_addr = 16'h0310;
    probe();
    chk("t3_next_issue", mem_rd, 1);
    chk("t3_next_addr", mem_addr, 16'h0310);
    chk("t3_no_mdone", m_done, 0);
    step(); mem_done = 1; mem_rdata = 16'h0F0F;
    probe();
    chk("t3_f_done", f_done, 1);
    step(); clr_in(); probe();

    // mem_err during WAIT
    step(); f_rd = 1; f_addr = 16'h0400;
    probe();
    chk("t4_issue", mem_rd, 1);
    step(); mem_err = 1;
    probe();
    chk("t4_err_not_yet", err, 0);
    chk("t4_no_done_err", f_done, 0);
    step(); mem_err = 0;
    probe();
    chk("t4_err_set", err, 1);
    chk("t4_no_done", f_done, 0);
    chk("t4_no_rd", mem_rd, 0);
    chk("t4_f_stall", f_stall, 1);
    step(); mem_done = 1; mem_rdata = 16'h3333;
    probe();
    chk("t4_err_done_blk", f_done, 0);
    step(); mem_done = 0; f_rd = 0; m_wr = 1; m_addr = 16'h0410; m_wdata = 16'h9999;
    probe();
    chk("t4_blk_wr", mem_wr, 0);
    chk("t4_blk_rd", mem_rd, 0);
    chk("t4_m_stall", m_stall, 1);
    chk("t4_err_held", err, 1);
    step(); clr_in(); rst = 1;
    probe();
    chk("t4_rst_err", err, 0);
    step(); rst = 0; f_rd = 1; f_addr = 16'h0420;
    probe();
    chk("t4_post_rst_rd", mem_rd, 1);
    chk("t4_post_rst_addr", mem_addr, 16'h0420);
    step(); mem_done = 1; mem_rdata = 16'h4242;
    probe();
    chk("t4_post_rst_done", f_done, 1);
    step(); clr_in(); probe();

    // illegal m_rd & m_wr in IDLE
    step(); m_rd = 1; m_wr = 1; m_addr = 16'h0430;
    probe();
    step(); probe();
    chk("t4b_err", err, 1);
    chk("t4b_no_rd", mem_rd, 0);
    chk("t4b_no_wr", mem_wr, 0);
    step(); clr_in(); rst = 1;
    step(); rst = 0;
    probe();
    chk("t4b_rst_err", err, 0);

    // reset asserted between edges during WAIT
    step(); f_rd = 1; f_addr = 16'h0500;
    probe();
    chk("t5_issue", mem_rd, 1);
    step(); probe();
    chk("t5_wait", mem_rd, 0);
    #2; rst = 1; mem_done = 1; mem_rdata = 16'h1111;
    #1;
    chk("t5_async_addr", mem_addr, 0);
    chk("t5_async_rd", mem_rd, 0);
    chk("t5_async_done", f_done, 0);
    chk("t5_async_data", f_data, 0);
    chk("t5_async_stall", f_stall, 1);
    step(); rst = 0; mem_done = 0; mem_rdata = '0;
    probe();
    chk("t5_reissue", mem_rd, 1);
    chk("t5_reissue_addr", mem_addr, 16'h0500);
    step(); probe();
    chk("t5_single_pulse", mem_rd, 0);
    chk("t5_hold_addr", mem_addr, 16'h0500);
    step(); mem_done = 1; mem_rdata = 16'h2222;
    probe();
    chk("t5_done", f_done, 1);
    chk("t5_data", f_data, 16'h2222);
    step(); clr_in(); probe();

    // F waiting against back-to-back M reads
    starve = 0;
    step(); f_rd = 1; f_addr = 16'h0600; m_rd = 1; m_addr = 16'h0700;
    for (int g = 0; g < 7; g++) begin
      exp_f = FAIR && (starve >= SM);
      probe();
      chk("t6_issue", mem_rd, 1);
      chk("t6_addr", mem_addr, exp_f ? f_addr : m_addr);
      step(); mem_done = 1; mem_rdata = 16'hC000 + 16'(g);
      probe();
      chk("t6_f_done", f_done, exp_f);
      chk("t6_m_done", m_done, !exp_f);
      step(); mem_done = 0;
      if (exp_f) begin f_addr = f_addr + 1; starve = 0; end
      else begin m_addr = m_addr + 1; starve++; end
    end
    clr_in(); probe();

    // randomized traffic against the transaction model
    step(); rst = 1;
    step(); rst = 0;
    for (int i = 0; i < 64; i++) mem_model[i] = DW'($urandom);
    fp = 0; mp = 0; busy = 0; own_m = 0; rem = 0; starve = 0;
    fa = '0; ma = '0; mwd = '0; mwr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      if (!fp && ($urandom_range(0, 2) == 0)) begin
        fp = 1; fa = AW'($urandom);
      end
      if (!mp && ($urandom_range(0, 2) == 0)) begin
        mp = 1; ma = AW'($urandom); mwr = 1'($urandom_range(0, 1)); mwd = DW'($urandom);
      end
      f_rd = fp; f_addr = fa;
      m_rd = mp && !mwr; m_wr = mp && mwr; m_addr = ma; m_wdata = mwd;
      issuing = 0;
      if (!busy && (fp || mp)) begin
        own_m   = mp && !(FAIR && fp && (starve >= SM));
        issuing = 1;
        busy    = 1;
        rem     = $urandom_range(0, 2);
      end
      cur_addr = own_m ? ma : fa;
      mem_done = busy && (rem == 0);
      rd_val   = mem_done ? mem_model[cur_addr[5:0]] : DW'($urandom);
      mem_rdata = rd_val;
      exp_fd = mem_done && !own_m;
      exp_md = mem_done && own_m;
      probe();
      chk("rnd_mem_rd", mem_rd, issuing && !(own_m && mwr));
      chk("rnd_mem_wr", mem_wr, issuing && own_m && mwr);
      if (busy) chk("rnd_mem_addr", mem_addr, cur_addr);
      if (issuing && own_m && mwr) chk("rnd_mem_wdata", mem_wdata, mwd);
      chk("rnd_f_done", f_done, exp_fd);
      chk("rnd_m_done", m_done, exp_md);
      chk("rnd_f_data", f_data, exp_fd ? rd_val : '0);
      chk("rnd_m_data", m_data, exp_md ? rd_val : '0);
      chk("rnd_f_stall", f_stall, fp && !exp_fd);
      chk("rnd_m_stall", m_stall, mp && !exp_md);
      if (!fp) starve = 0;
      else if (issuing && !own_m) starve = 0;
      else if (issuing && own_m && (starve < SM)) starve++;
      if (mem_done) begin
        if (own_m && mwr) mem_model[ma[5:0]] = mwd;
        if (own_m) mp = 0; else fp = 0;
        busy = 0;
      end else if (busy) begin
        rem--;
      end
    end
    chk("rnd_err_clear", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
